// File: rtl/ll_pkg.sv
// Shared types for the linked-list read request front end.
// Optional build macro used by the users of this package: LL_RD_TIMEOUT_EN.
package ll_pkg;

    localparam int unsigned PTR_WD     = 4;
    localparam int unsigned WR_DATA_WD = 8;

    // One buffered host request: pop flag plus node position.
    typedef struct packed {
        logic              pop;
        logic [PTR_WD-1:0] pos;
    } rd_req_entry_t;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StResp
    } t_rd_req_st;

endpackage

// File: rtl/ll_rd_req_fifo.sv
// Small synchronous FIFO for host read requests. Pointers carry one extra
// wrap bit so full and empty are told apart by the MSB.
module ll_rd_req_fifo #(
    parameter int unsigned Width = 5,
    parameter int unsigned Depth = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [Width-1:0] rd_data_o,
    output logic             empty_o,
    output logic             full_nxt_o
);

    localparam int unsigned AddrW = $clog2(Depth);

    logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
    logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
    logic [Width-1:0] mem_q [Depth];
    logic             full, wr_fire, rd_fire;

    assign empty_o   = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                       (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    assign wr_fire   = wr_en_i && !full;
    assign rd_fire   = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rd_ptr_q[AddrW-1:0]];

    // Next pointers, and the full flag they imply, so the owner can register ready.
    always_comb begin
        wr_ptr_d   = wr_ptr_q + {{AddrW{1'b0}}, wr_fire};
        rd_ptr_d   = rd_ptr_q + {{AddrW{1'b0}}, rd_fire};
        full_nxt_o = (wr_ptr_d[AddrW] != rd_ptr_d[AddrW]) &&
                     (wr_ptr_d[AddrW-1:0] == rd_ptr_d[AddrW-1:0]);
    end

    // Pointer state; synchronous active-low reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/ll_rd_req_intf.sv
// Host-facing read front end of the linked-list engine: buffers requests,
// range-checks them against the node count, issues one at a time to the read
// controller and returns data or an error on a valid/ready response channel.
// Optional build macro: LL_RD_TIMEOUT_EN adds an ISSUE-state watchdog.
// The FIFO entry layout comes from ll_pkg, so PTR_WD must equal ll_pkg::PTR_WD.
module ll_rd_req_intf #(
    parameter int unsigned PTR_WD         = ll_pkg::PTR_WD,
    parameter int unsigned WR_DATA_WD     = ll_pkg::WR_DATA_WD,
    parameter int unsigned REQ_FIFO_DEPTH = 4
`ifdef LL_RD_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYC    = 64
`endif
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  host_rd_req_vld,
    output logic                  host_rd_req_rdy,
    input  logic                  host_rd_req_pop,
    input  logic [PTR_WD-1:0]     host_rd_req_pos,
    output logic                  host_rd_resp_vld,
    input  logic                  host_rd_resp_rdy,
    output logic [WR_DATA_WD-1:0] host_rd_resp_data,
    output logic                  host_rd_resp_err,
    input  logic [PTR_WD:0]       ll_node_cnt,
    output logic                  rd_req_vld,
    output logic                  rd_req_pop,
    output logic [PTR_WD-1:0]     rd_node_at_pos,
    input  logic                  rd_ctrl_ready,
    input  logic                  rd_data_out_vld,
    input  logic [WR_DATA_WD-1:0] rd_data_out
);
    import ll_pkg::*;

    t_rd_req_st            state_q, state_d;
    rd_req_entry_t         wr_entry, head;
    logic                  fifo_wr, fifo_rd, fifo_empty, fifo_full_nxt;
    logic                  head_err;
    logic                  rdy_q;
    logic                  resp_vld_q, resp_vld_d;
    logic                  resp_err_q, resp_err_d;
    logic [WR_DATA_WD-1:0] resp_data_q, resp_data_d;
    logic                  req_vld_q, req_vld_d;
    logic                  req_pop_q, req_pop_d;
    logic [PTR_WD-1:0]     req_pos_q, req_pos_d;

`ifdef LL_RD_TIMEOUT_EN
    localparam int unsigned TmoW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [TmoW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            tmo_hit;
    assign tmo_hit = (tmo_cnt_q == TmoW'(TIMEOUT_CYC - 1));
`endif

    assign wr_entry.pop = host_rd_req_pop;
    assign wr_entry.pos = host_rd_req_pos;
    assign fifo_wr      = host_rd_req_vld && rdy_q;

    ll_rd_req_fifo #(
        .Width ($bits(rd_req_entry_t)),
        .Depth (REQ_FIFO_DEPTH)
    ) u_req_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en_i    (fifo_wr),
        .wr_data_i  (wr_entry),
        .rd_en_i    (fifo_rd),
        .rd_data_o  (head),
        .empty_o    (fifo_empty),
        .full_nxt_o (fifo_full_nxt)
    );

    // Reject positions past the list end and pops from an empty list.
    assign head_err = ({1'b0, head.pos} >= ll_node_cnt) ||
                      (head.pop && (ll_node_cnt == '0));

    // Next-state and registered-output decode for the request FSM.
    always_comb begin
        state_d     = state_q;
        fifo_rd     = 1'b0;
        resp_vld_d  = resp_vld_q;
        resp_err_d  = resp_err_q;
        resp_data_d = resp_data_q;
        req_vld_d   = req_vld_q;
        req_pop_d   = req_pop_q;
        req_pos_d   = req_pos_q;
`ifdef LL_RD_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty && rd_ctrl_ready) begin
                    fifo_rd = 1'b1;
                    if (head_err) begin
                        resp_vld_d  = 1'b1;
                        resp_err_d  = 1'b1;
                        resp_data_d = '0;
                        state_d     = StResp;
                    end else begin
                        req_vld_d = 1'b1;
                        req_pop_d = head.pop;
                        req_pos_d = head.pos;
`ifdef LL_RD_TIMEOUT_EN
                        tmo_cnt_d = '0;
`endif
                        state_d   = StIssue;
                    end
                end
            end
            StIssue: begin
`ifdef LL_RD_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 1'b1;
`endif
                if (rd_data_out_vld) begin
                    resp_vld_d  = 1'b1;
                    resp_err_d  = 1'b0;
                    resp_data_d = rd_data_out;
                    req_vld_d   = 1'b0;
                    req_pop_d   = 1'b0;
                    req_pos_d   = '0;
                    state_d     = StResp;
                end
`ifdef LL_RD_TIMEOUT_EN
                else if (tmo_hit) begin
                    resp_vld_d  = 1'b1;
                    resp_err_d  = 1'b1;
                    resp_data_d = '0;
                    req_vld_d   = 1'b0;
                    req_pop_d   = 1'b0;
                    req_pos_d   = '0;
                    state_d     = StResp;
                end
`endif
            end
            StResp: begin
                if (host_rd_resp_rdy) begin
                    resp_vld_d  = 1'b0;
                    resp_err_d  = 1'b0;
                    resp_data_d = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset drops any in-flight request silently.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            rdy_q       <= 1'b0;
            resp_vld_q  <= 1'b0;
            resp_err_q  <= 1'b0;
            resp_data_q <= '0;
            req_vld_q   <= 1'b0;
            req_pop_q   <= 1'b0;
            req_pos_q   <= '0;
`ifdef LL_RD_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rdy_q       <= !fifo_full_nxt;
            resp_vld_q  <= resp_vld_d;
            resp_err_q  <= resp_err_d;
            resp_data_q <= resp_data_d;
            req_vld_q   <= req_vld_d;
            req_pop_q   <= req_pop_d;
            req_pos_q   <= req_pos_d;
`ifdef LL_RD_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign host_rd_req_rdy   = rdy_q;
    assign host_rd_resp_vld  = resp_vld_q;
    assign host_rd_resp_err  = resp_err_q;
    assign host_rd_resp_data = resp_data_q;
    assign rd_req_vld        = req_vld_q;
    assign rd_req_pop        = req_pop_q;
    assign rd_node_at_pos    = req_pos_q;

endmodule

// File: doc/ll_rd_req_intf.md
Name: ll_rd_req_intf

Overview:
Host-facing read front end for the linked-list engine; sits directly upstream of the read controller.
- Buffers host read/pop requests in a small FIFO and range-checks each against the current list node count.
- Issues one request at a time to the read controller, holding the request lines stable until read data returns.
- Returns data, or an error for out-of-range requests, to the host over a valid/ready response channel.

Parameters:
PTR_WD, 4, node position/pointer width
WR_DATA_WD, 8, data word width
REQ_FIFO_DEPTH, 4, request FIFO entries; power of two, >=2
TIMEOUT_CYC, 64, watchdog limit in cycles; used only with LL_RD_TIMEOUT_EN

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
host_rd_req_vld  in  1  host request valid
host_rd_req_rdy  out  1  request accepted when vld&rdy
host_rd_req_pop  in  1  1=read-and-remove node, 0=read only
host_rd_req_pos  in  PTR_WD  node position
host_rd_resp_vld  out  1  response valid
host_rd_resp_rdy  in  1  host accepts response
host_rd_resp_data  out  WR_DATA_WD  read data; 0 on error
host_rd_resp_err  out  1  request rejected or timed out
ll_node_cnt  in  PTR_WD+1  current number of nodes in list
rd_req_vld  out  1  request to read controller
rd_req_pop  out  1  pop flag to read controller
rd_node_at_pos  out  PTR_WD  position to read controller
rd_ctrl_ready  in  1  read controller idle
rd_data_out_vld  in  1  read data valid (single-cycle pulse)
rd_data_out  in  WR_DATA_WD  read data

Behaviour:
Reset: all outputs are registered.
- Reset values: host_rd_req_rdy=0 during reset, 1 on the first cycle after reset.
- host_rd_resp_vld=0, host_rd_resp_data=0, host_rd_resp_err=0.
- rd_req_vld=0, rd_req_pop=0, rd_node_at_pos=0.
- FIFO is emptied and the FSM returns to IDLE.
- Reset mid-operation drops the in-flight request; no response is produced for it.

FIFO:
- Entry = {pop, pos}; write on host_rd_req_vld & host_rd_req_rdy.
- host_rd_req_rdy = !full.
- Simultaneous write and read while non-empty is legal, and occupancy is unchanged.
- Pointers are PTR_WD-independent, log2(REQ_FIFO_DEPTH)+1 bits; wrap is detected via the MSB.

FSM states: IDLE, ISSUE, RESP.
- IDLE: when FIFO is non-empty and rd_ctrl_ready=1, read the head and range-check it.
  - Error if pos >= ll_node_cnt, or if pop=1 and ll_node_cnt==0.
  - Error: load host_rd_resp_data=0 and err=1, go to RESP.
  - Valid: register rd_req_vld=1 with pop/pos, go to ISSUE.
- ISSUE: hold rd_req_vld, rd_req_pop and rd_node_at_pos stable every cycle.
  - On rd_data_out_vld: capture rd_data_out, drop rd_req_vld/pop/pos to 0 next cycle, set err=0, go to RESP.
- RESP: assert host_rd_resp_vld until host_rd_resp_rdy.
  - On handshake: clear vld/data/err and go to IDLE.
  - The next issue cannot occur before the following cycle.
- rd_data_out_vld outside ISSUE is ignored.

Latency (no backpressure): request accepted cycle N → head visible N+1 → rd_req_vld high N+2. The error response is valid at N+2.

Ordering: responses return strictly in request order.

ll_node_cnt is sampled only at the IDLE check.

Optional Feature:
LL_RD_TIMEOUT_EN:
- Defined: a counter clears on entry to ISSUE and increments each ISSUE cycle.
  - Reaching TIMEOUT_CYC-1 without rd_data_out_vld: deassert rd_req_vld, respond with err=1 and data=0, go to RESP.
  - A late rd_data_out_vld is ignored.
- Undefined: no counter; ISSUE waits indefinitely.

Decomposition:
- Package ll_pkg: PTR_WD and WR_DATA_WD constants, the rd_req_entry_t struct {pop, pos}, and the FSM state enum t_rd_req_st.
- One sub-module: ll_rd_req_fifo, a parameterized synchronous FIFO with full/empty flags.

Test Plan:
- Basic read: ll_node_cnt=5, request pos=2 pop=0; controller returns 0xA5 after 4 cycles → rd_req_vld held with pos=2 through the data cycle; host response data=0xA5, err=0.
- Out of range: ll_node_cnt=3, request pos=3 → rd_req_vld never asserts; response err=1, data=0 at cycle N+2.
- Pop on empty: ll_node_cnt=0, pop=1 pos=0 → err=1. Then set ll_node_cnt=1 and repeat → rd_req_pop=1 issued.
- FIFO full/backpressure: host_rd_resp_rdy=0 while sending 6 requests → host_rd_req_rdy falls after 4 are buffered plus 1 in flight. Release → 6 in-order responses.
- Reset mid-operation: assert reset_n=0 in ISSUE → next cycle rd_req_vld=0, FIFO empty, no response; a new request afterwards completes normally.
- With LL_RD_TIMEOUT_EN and TIMEOUT_CYC=8: controller never returns data → rd_req_vld drops after 8 ISSUE cycles and response err=1. A later rd_data_out_vld pulse produces no response.
